// File: rtl/rr_arbiter_onehot_pkg.sv
// Shared constants and types for the round-robin one-hot arbiter and the
// 8-to-3 encoder stage it feeds.
//   ARB_N      number of requesters / one-hot grant width (encoder input width)
//   ARB_IDX_W  index width, $clog2(ARB_N) (encoder output width)
//   arb_state_t  arbiter FSM encoding
package rr_arbiter_onehot_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_onehot_pick.sv
// rr_pick: purely combinational round-robin selection.
//   req          in   N      candidate request vector
//   last_ptr     in   IDX_W  index of the most recently accepted grant
//   pick_onehot  out  N      selected requester, one-hot (zero if req==0)
//   pick_idx     out  IDX_W  index of the selected requester
//   pick_any     out  1      at least one candidate present
// Requesters strictly above last_ptr win first; if none are present the
// search wraps to the lowest set bit of the full vector.
module rr_pick
  import rr_arbiter_onehot_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     pick_onehot,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic [N-1:0] above_mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  always_comb begin
    above_mask = '0;
    for (int i = 0; i < N; i++) begin
      above_mask[i] = (i > int'(last_ptr));
    end
    masked = req & above_mask;
    src    = (masked != '0) ? masked : req;
    // Two's-complement trick isolates the lowest set bit, so the result is
    // one-hot by construction (or zero when src is zero).
    pick_onehot = src & (~src + N'(1));
    pick_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
    pick_any = |req;
  end

endmodule

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: round-robin arbiter with a registered one-hot grant that
// drives the downstream 8-to-3 encoder directly.
//   clk           in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high
//   req           in   N      level requests, bit i = requester i
//   grant_ready   in   1      consumer takes the current grant this cycle
//   grant_valid   out  1      grant_onehot carries a valid grant
//   grant_onehot  out  N      registered one-hot grant (all-zero when idle)
//   last_ptr      out  IDX_W  index of the most recently accepted grant
//
// Handshake: a grant transfers on a rising edge where grant_valid and
// grant_ready are both high. While grant_valid is high and grant_ready is low
// the grant is held unchanged (never retracted, even if its req bit drops).
// grant_ready is ignored while grant_valid is low.
module rr_arbiter_onehot
  import rr_arbiter_onehot_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] last_ptr
);

  arb_state_t       state, state_nxt;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [IDX_W-1:0] last_ptr_q;

  logic [N-1:0]     pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             handshake;

  assign handshake = (state == ST_GRANT) && grant_ready;

  // In GRANT the picker already looks ahead: the granted bit is removed and
  // the pointer is the grant being accepted, so the next winner can be
  // registered on the handshake edge with no idle bubble.
  always_comb begin
    pick_req = req;
    pick_ptr = last_ptr_q;
    if (state == ST_GRANT) begin
      pick_req = req & ~grant_q;
      pick_ptr = grant_idx_q;
    end
  end

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req         (pick_req),
    .last_ptr    (pick_ptr),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_any    (pick_any)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_GRANT;
      ST_GRANT: if (handshake && !pick_any) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    grant_valid = (state == ST_GRANT);
  end

  // Grant and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_ptr_q  <= IDX_W'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_onehot;
            grant_idx_q <= pick_idx;
          end
        end
        ST_GRANT: begin
          if (grant_ready) begin
            last_ptr_q <= grant_idx_q;
            if (pick_any) begin
              grant_q     <= pick_onehot;
              grant_idx_q <= pick_idx;
            end else begin
              grant_q <= '0;
            end
          end
        end
        default: grant_q <= '0;
      endcase
    end
  end

  assign grant_onehot = grant_q;
  assign last_ptr     = last_ptr_q;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
module tb_rr_arbiter_onehot;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       grant_ready = 1'b0;
  logic       grant_valid;
  logic [7:0] grant_onehot;
  logic [2:0] last_ptr;

  int total = 0;
  int bad   = 0;

  // expected grant indices, front = grant currently offered
  logic [W-1:0] exp_q[$];

  // reference model state (state after the most recent clock edge)
  bit m_valid = 1'b0;
  int m_grant = 0;
  int m_last  = 7;

  // monitor bookkeeping for post-handshake last_ptr check
  bit         last_pend = 1'b0;
  logic [2:0] last_exp  = '0;

  rr_arbiter_onehot dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .last_ptr     (last_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // bench-side 8-to-3 encoder, as the downstream stage would see it
  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // round-robin rule: scan upward from the slot after 'last', wrapping
  function automatic int next_grant(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (last + k) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // advance the model across the coming clock edge using the current inputs
  task automatic model_step();
    logic [7:0] rest;
    if (!m_valid) begin
      if (req != 8'h00) begin
        m_grant = next_grant(req, m_last);
        m_valid = 1'b1;
        exp_q.push_back(W'(m_grant));
      end
    end else if (grant_ready) begin
      m_last = m_grant;
      rest   = req & ~(8'h01 << m_grant);
      if (rest != 8'h00) begin
        m_grant = next_grant(rest, m_last);
        exp_q.push_back(W'(m_grant));
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // driver: called at posedge+1, returns at the following posedge+1
  task automatic do_cycle(input logic [7:0] r, input logic rdy);
    req         = r;
    grant_ready = rdy;
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] r);
    reset       = 1'b1;
    req         = r;
    grant_ready = 1'b0;
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = 7;
    #1;
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant", 32'(grant_onehot), 32'd0);
    chk("rst_last_ptr", 32'(last_ptr), 32'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // scoreboard monitor: sampled on the falling edge, away from updates
  always @(negedge clk) begin
    if (reset) begin
      last_pend = 1'b0;
    end else begin
      if (last_pend) chk("last_ptr", 32'(last_ptr), 32'(last_exp));
      last_pend = 1'b0;
      if (grant_valid) chk("onehot_inv", 32'($onehot(grant_onehot)), 32'd1);
      else             chk("idle_zero", 32'(grant_onehot), 32'd0);
      chk("valid", 32'(grant_valid), 32'(exp_q.size() != 0));
      if (grant_valid && exp_q.size() != 0) begin
        chk("grant", 32'(grant_onehot), 32'(8'h01 << exp_q[0]));
        if (grant_ready) begin
          last_exp  = exp_q.pop_front();
          chk("enc_idx", 32'(enc8(grant_onehot)), 32'(last_exp));
          last_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;

    // 1: reset with all requests high, first grant to requester 0
    apply_reset(8'hFF);
    do_cycle(8'hFF, 1'b0);
    chk("t1_valid", 32'(grant_valid), 32'd1);
    chk("t1_grant", 32'(grant_onehot), 32'h01);

    // 2: continuous ready, one grant per cycle rotating 01..80,01
    apply_reset(8'hFF);
    for (int k = 0; k < 10; k++) begin
      do_cycle(8'hFF, 1'b1);
      chk("t2_seq", 32'(grant_onehot), 32'(8'h01 << (k % 8)));
    end

    // 3: grant held while ready low, then advances
    apply_reset(8'h00);
    for (int k = 0; k < 5; k++) begin
      do_cycle(8'h11, 1'b0);
      chk("t3_hold", 32'(grant_onehot), 32'h01);
    end
    do_cycle(8'h11, 1'b1);
    chk("t3_next", 32'(grant_onehot), 32'h10);
    chk("t3_last", 32'(last_ptr), 32'd0);

    // 4: wrap from last_ptr=6, then lone requester 6
    apply_reset(8'h00);
    do_cycle(8'h40, 1'b0);
    do_cycle(8'h41, 1'b1);
    chk("t4_last6", 32'(last_ptr), 32'd6);
    chk("t4_wrap", 32'(grant_onehot), 32'h01);
    do_cycle(8'h40, 1'b1);
    chk("t4_g40", 32'(grant_onehot), 32'h40);

    // 5: request dropped under a pending grant, accept returns to idle
    apply_reset(8'h00);
    do_cycle(8'h04, 1'b0);
    chk("t5_g04", 32'(grant_onehot), 32'h04);
    do_cycle(8'h00, 1'b1);
    chk("t5_valid", 32'(grant_valid), 32'd0);
    chk("t5_grant", 32'(grant_onehot), 32'h00);
    chk("t5_last", 32'(last_ptr), 32'd2);

    // 6: reset while a grant is pending clears outputs asynchronously
    apply_reset(8'h00);
    do_cycle(8'h08, 1'b0);
    chk("t6_g08", 32'(grant_onehot), 32'h08);
    apply_reset(8'h08);
    do_cycle(8'h00, 1'b0);

    // random phase against the reference model
    apply_reset(8'h00);
    for (int k = 0; k < 400; k++) begin
      do_cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 12; k++) do_cycle(8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
